// File: rtl/ring_token_arbiter.sv
`default_nettype none
// ring_token_arbiter: per-core ring output stage that captures the Token, grants it round-robin to
// local clients and strips returning own slots. Optional ringError port via RING_ARB_ERR_EN. Rev 1.0
module ring_token_arbiter #(
  parameter int         NREQ       = 3,
  parameter int         MAX_BURST  = 4,
  parameter logic [3:0] TOKEN_TYPE = 4'd1,
  parameter logic [3:0] NULL_TYPE  = 4'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           whichCore,
  input  logic [31:0]          RingIn,
  input  logic [3:0]           SlotTypeIn,
  input  logic [3:0]           SourceIn,
  output logic [31:0]          RingOut,
  output logic [3:0]           SlotTypeOut,
  output logic [3:0]           SourceOut,
  input  logic [NREQ-1:0]      wantsToken,
  output logic [NREQ-1:0]      acquireToken,
  input  logic [NREQ-1:0]      driveRing,
  input  logic [32*NREQ-1:0]   reqRingOut,
  input  logic [4*NREQ-1:0]    reqSlotTypeOut,
  input  logic [4*NREQ-1:0]    reqSourceOut,
  output logic                 holdingToken
`ifdef RING_ARB_ERR_EN
  ,
  output logic                 ringError
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    ST_FORWARD = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [3:0]    burst_q, burst_d;
  logic [31:0]   ring_q, ring_d;
  logic [3:0]    type_q, type_d;
  logic [3:0]    src_q, src_d;

  logic          w_is_token, w_is_null, w_own, w_free, w_grant, w_found;
  logic [PW-1:0] w_gidx;
  logic [PW:0]   w_sum, w_next;
  logic [NREQ-1:0] w_gnt;

  assign w_is_token = (SlotTypeIn == TOKEN_TYPE);
  assign w_is_null  = (SlotTypeIn == NULL_TYPE);
  assign w_own      = (SourceIn == whichCore);
  // In HOLD a second Token is never a free slot, even if it carries our source.
  assign w_free     = !w_is_token && (w_is_null || w_own);

  // Round-robin search: first requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      if (!w_found && wantsToken[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_grant = 1'b0;
    if (!reset && w_found) begin
      if (state_q == ST_FORWARD) w_grant = w_is_token;
      else                       w_grant = w_free && (burst_q < 4'(MAX_BURST));
    end
    for (int i = 0; i < NREQ; i++) w_gnt[i] = w_grant && (w_gidx == PW'(i));
    w_next = {1'b0, w_gidx} + 1'b1;
    if (w_next == (PW+1)'(NREQ)) w_next = '0;
  end

  assign acquireToken = w_gnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    ring_d  = RingIn;
    type_d  = SlotTypeIn;
    src_d   = SourceIn;
    if (w_grant) begin
      // A granted client that does not drive still consumes its burst slot as an empty one.
      ring_d = '0;
      type_d = NULL_TYPE;
      src_d  = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i] && driveRing[i]) begin
          ring_d = reqRingOut[32*i +: 32];
          type_d = reqSlotTypeOut[4*i +: 4];
          src_d  = reqSourceOut[4*i +: 4];
        end
      end
      state_d = ST_HOLD;
      burst_d = (state_q == ST_HOLD) ? burst_q + 4'd1 : 4'd1;
      ptr_d   = w_next[PW-1:0];
    end else if (state_q == ST_HOLD && w_free) begin
      ring_d  = '0;
      type_d  = TOKEN_TYPE;
      src_d   = whichCore;
      state_d = ST_FORWARD;
      burst_d = '0;
    end else if (state_q == ST_FORWARD && !w_is_token && w_own && !w_is_null) begin
      ring_d = '0;
      type_d = NULL_TYPE;
      src_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FORWARD;
      ptr_q   <= '0;
      burst_q <= '0;
      ring_q  <= '0;
      type_q  <= NULL_TYPE;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      ring_q  <= ring_d;
      type_q  <= type_d;
      src_q   <= src_d;
    end
  end

  assign RingOut      = ring_q;
  assign SlotTypeOut  = type_q;
  assign SourceOut    = src_q;
  assign holdingToken = (state_q == ST_HOLD);

`ifdef RING_ARB_ERR_EN
  logic err_q;
  logic w_err;

  assign w_err = ((state_q == ST_HOLD) && !w_free) || (|(driveRing & ~w_gnt));

  always_ff @(posedge clock) begin
    if (reset)      err_q <= 1'b0;
    else if (w_err) err_q <= 1'b1;
  end

  assign ringError = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_token_arbiter.sv
`default_nettype none
// tb_ring_token_arbiter: directed test-plan scenarios followed by randomized traffic, all checked
// against a slot-level reference model of the token protocol.
module tb_ring_token_arbiter;

  localparam int         NREQ = 3;
  localparam int         MAXB = 4;
  localparam logic [3:0] TOK  = 4'd1;
  localparam logic [3:0] NUL  = 4'd0;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [3:0]          whichCore = 4'd2;
  logic [31:0]         RingIn = '0;
  logic [3:0]          SlotTypeIn = NUL;
  logic [3:0]          SourceIn = '0;
  logic [31:0]         RingOut;
  logic [3:0]          SlotTypeOut;
  logic [3:0]          SourceOut;
  logic [NREQ-1:0]     wantsToken = '0;
  logic [NREQ-1:0]     acquireToken;
  logic [NREQ-1:0]     driveRing = '0;
  logic [32*NREQ-1:0]  reqRingOut = '0;
  logic [4*NREQ-1:0]   reqSlotTypeOut = '0;
  logic [4*NREQ-1:0]   reqSourceOut = '0;
  logic                holdingToken;
`ifdef RING_ARB_ERR_EN
  logic                ringError;
`endif

  ring_token_arbiter #(
    .NREQ(NREQ), .MAX_BURST(MAXB), .TOKEN_TYPE(TOK), .NULL_TYPE(NUL)
  ) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .wantsToken(wantsToken), .acquireToken(acquireToken), .driveRing(driveRing),
    .reqRingOut(reqRingOut), .reqSlotTypeOut(reqSlotTypeOut), .reqSourceOut(reqSourceOut),
    .holdingToken(holdingToken)
`ifdef RING_ARB_ERR_EN
    , .ringError(ringError)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: whether we own the token, slots sent this capture, next requester to favour.
  int          m_hold = 0;
  int          m_cnt  = 0;
  int          m_ptr  = 0;
  logic [31:0] m_ring = '0;
  logic [3:0]  m_type = NUL;
  logic [3:0]  m_src  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
  endtask

  task automatic step(input logic r, input logic [3:0] st, input logic [3:0] sr,
                      input logic [31:0] pl, input logic [NREQ-1:0] wt, input logic [NREQ-1:0] dr);
    int   g;
    bit   free, can;
    logic [NREQ-1:0] exp_acq;
    @(negedge clock);
    reset = r; SlotTypeIn = st; SourceIn = sr; RingIn = pl; wantsToken = wt; driveRing = dr;
    for (int i = 0; i < NREQ; i++) begin
      reqRingOut[32*i +: 32]   = $urandom;
      reqSlotTypeOut[4*i +: 4] = 4'($urandom_range(2, 15));
      reqSourceOut[4*i +: 4]   = whichCore;
    end
    #1;
    g    = -1;
    free = (st != TOK) && (st == NUL || sr == whichCore);
    can  = (m_hold != 0) ? (free && m_cnt < MAXB) : (st == TOK);
    if (!r && can)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && wt[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_acq = '0;
    if (g >= 0) exp_acq[g] = 1'b1;
    check("acquireToken", 32'(acquireToken), 32'(exp_acq));

    if (r) begin
      m_hold = 0; m_cnt = 0; m_ptr = 0; m_ring = '0; m_type = NUL; m_src = '0;
    end else if (g >= 0) begin
      if (dr[g]) begin
        m_ring = reqRingOut[32*g +: 32]; m_type = reqSlotTypeOut[4*g +: 4]; m_src = reqSourceOut[4*g +: 4];
      end else begin
        m_ring = '0; m_type = NUL; m_src = '0;
      end
      m_cnt  = (m_hold != 0) ? m_cnt + 1 : 1;
      m_hold = 1;
      m_ptr  = (g + 1) % NREQ;
    end else if (m_hold != 0 && free) begin
      m_ring = '0; m_type = TOK; m_src = whichCore; m_hold = 0; m_cnt = 0;
    end else if (m_hold == 0 && st != TOK && st != NUL && sr == whichCore) begin
      m_ring = '0; m_type = NUL; m_src = '0;
    end else begin
      m_ring = pl; m_type = st; m_src = sr;
    end

    @(posedge clock);
    #1;
    check("RingOut", RingOut, m_ring);
    check("SlotTypeOut", 32'(SlotTypeOut), 32'(m_type));
    check("SourceOut", 32'(SourceOut), 32'(m_src));
    check("holdingToken", 32'(holdingToken), 32'(m_hold));
  endtask

  initial begin
    logic [NREQ-1:0] wr;
    logic [3:0]      st;
    int              rr;

    step(1, NUL, 0, 0, 0, 0);
    step(1, 4'd3, 5, 32'h1234, 3'b111, 0);
    // idle forwarding and token pass-through
    step(0, 4'd3, 5, 32'hA5A5_0001, 0, 0);
    step(0, 4'd7, 5, 32'hA5A5_0002, 0, 0);
    step(0, TOK, 5, 32'h0, 0, 0);
    // single Barrier grant, then token re-emitted
    step(0, TOK, 6, 32'h0, 3'b001, 3'b001);
    step(0, NUL, 0, 32'h0, 3'b000, 0);
    // round-robin burst up to the limit, then next capture
    step(0, TOK, 6, 0, 3'b111, 3'b111);
    for (int i = 0; i < 5; i++) step(0, NUL, 0, 0, 3'b111, 3'b111);
    step(0, TOK, 6, 0, 3'b111, 3'b111);
    step(0, NUL, 0, 0, 3'b000, 0);
    // strip own returning slot
    step(0, 4'd3, 2, 32'hDEAD_BEEF, 0, 0);
    // foreign slot and duplicate token while holding; undriven grant
    step(0, TOK, 6, 0, 3'b010, 3'b000);
    step(0, 4'd3, 7, 32'h7777_0000, 3'b010, 3'b010);
    step(0, TOK, 4, 0, 3'b010, 3'b010);
    step(0, 4'd5, 2, 32'h2222_0000, 3'b010, 3'b010);
    step(0, NUL, 0, 0, 3'b000, 0);
    // reset while holding drops the token
    step(0, TOK, 6, 0, 3'b100, 3'b100);
    step(1, NUL, 0, 0, 3'b100, 3'b100);
    step(0, NUL, 0, 0, 3'b000, 0);

    wr = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 35) wr = NREQ'($urandom);
      rr = $urandom_range(0, 99);
      if (rr < 20)      st = TOK;
      else if (rr < 60) st = NUL;
      else              st = 4'($urandom_range(2, 15));
      step(($urandom_range(0, 99) < 2), st, 4'($urandom_range(0, 7)), $urandom, wr,
           ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : {NREQ{1'b1}});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
